// File: rtl/lcg_pkg.sv
// Shared FSM state encoding and the LCG step used by every lane of lcg_seed_search.
// The step works at LCG_MAX_W bits, so the search supports WIDTH up to 64.
package lcg_pkg;

  localparam int LCG_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full product plus increment is kept before the reduction so no bits are lost.
  function automatic logic [LCG_MAX_W-1:0] lcg_step(
    input logic [LCG_MAX_W-1:0] seed,
    input logic [LCG_MAX_W-1:0] a,
    input logic [LCG_MAX_W-1:0] c,
    input logic [LCG_MAX_W-1:0] m
  );
    logic [2*LCG_MAX_W:0] acc;
    logic [2*LCG_MAX_W:0] rem;
    acc = ({{(LCG_MAX_W+1){1'b0}}, seed} * {{(LCG_MAX_W+1){1'b0}}, a})
        + {{(LCG_MAX_W+1){1'b0}}, c};
    if (m == '0) rem = '0;
    else         rem = acc % {{(LCG_MAX_W+1){1'b0}}, m};
    return rem[LCG_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/lcg_lane.sv
// One candidate-seed lane: a NUM_OBS-deep chain of LCG steps compared against
// the observed outputs. Purely combinational.
module lcg_lane
  import lcg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OBS = 3
) (
  input  logic                     en,
  input  logic [WIDTH-1:0]         seed,
  input  logic [WIDTH-1:0]         multiplier,
  input  logic [WIDTH-1:0]         increment,
  input  logic [WIDTH-1:0]         modulus,
  input  logic [NUM_OBS*WIDTH-1:0] expected,
  output logic                     match
);

  logic [WIDTH-1:0]   vals [NUM_OBS];
  logic [NUM_OBS-1:0] hit;

  for (genvar k = 0; k < NUM_OBS; k++) begin : g_step
    if (k == 0) begin : g_first
      assign vals[k] = WIDTH'(lcg_step(LCG_MAX_W'(seed), LCG_MAX_W'(multiplier),
                                       LCG_MAX_W'(increment), LCG_MAX_W'(modulus)));
    end else begin : g_next
      assign vals[k] = WIDTH'(lcg_step(LCG_MAX_W'(vals[k-1]), LCG_MAX_W'(multiplier),
                                       LCG_MAX_W'(increment), LCG_MAX_W'(modulus)));
    end
    assign hit[k] = (vals[k] == expected[k*WIDTH +: WIDTH]);
  end

  assign match = en & (&hit);

endmodule

// File: rtl/lcg_seed_search.sv
// Brute-force LCG seed search over [seed_lo, seed_hi], LANES seeds per cycle.
// Define LCG_SEARCH_MULTI_MATCH_EN to keep scanning past the first matching block.
module lcg_seed_search
  import lcg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OBS = 3,
  parameter int LANES   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [WIDTH-1:0]         modulus,
  input  logic [WIDTH-1:0]         multiplier,
  input  logic [WIDTH-1:0]         increment,
  input  logic [WIDTH-1:0]         seed_lo,
  input  logic [WIDTH-1:0]         seed_hi,
  input  logic [NUM_OBS*WIDTH-1:0] expected,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [WIDTH-1:0]         valid_seed,
  output logic                     match_valid,
  output logic [WIDTH-1:0]         match_seed,
  output logic [WIDTH-1:0]         match_count,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(LANES + 1);

  state_t                   state;
  logic [WIDTH-1:0]         cfg_mod, cfg_mul, cfg_inc, cfg_hi;
  logic [NUM_OBS*WIDTH-1:0] cfg_exp;
  // One spare bit so base + LANES - 1 can pass the top of the seed space without wrapping.
  logic [WIDTH:0]           base;

  logic [WIDTH:0]   lane_full [LANES];
  logic [WIDTH-1:0] lane_seed [LANES];
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] lane_hit;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_full[i] = base + (WIDTH+1)'(i);
    assign lane_en[i]   = (lane_full[i] <= {1'b0, cfg_hi});
    assign lane_seed[i] = lane_full[i][WIDTH-1:0];

    lcg_lane #(.WIDTH(WIDTH), .NUM_OBS(NUM_OBS)) u_lane (
      .en         (lane_en[i]),
      .seed       (lane_seed[i]),
      .multiplier (cfg_mul),
      .increment  (cfg_inc),
      .modulus    (cfg_mod),
      .expected   (cfg_exp),
      .match      (lane_hit[i])
    );
  end

  logic [CW-1:0]    hit_cnt;
  logic [WIDTH-1:0] hit_seed;
  logic             hit_any;
  logic             last_blk;
  logic             stop_on_hit;
  logic             bad_cfg;

  // Walk downward so the lowest matching lane wins.
  always_comb begin
    hit_cnt  = '0;
    hit_seed = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      hit_cnt = hit_cnt + CW'(lane_hit[i]);
      if (lane_hit[i]) hit_seed = lane_seed[i];
    end
  end

  assign hit_any  = |lane_hit;
  assign last_blk = (base + (WIDTH+1)'(LANES - 1)) >= {1'b0, cfg_hi};
  assign bad_cfg  = (seed_lo > seed_hi) || (modulus == '0);

`ifdef LCG_SEARCH_MULTI_MATCH_EN
  assign stop_on_hit = 1'b0;
`else
  assign stop_on_hit = hit_any;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      match_valid <= 1'b0;
      valid_seed  <= '0;
      match_seed  <= '0;
      match_count <= '0;
      base        <= '0;
      cfg_mod     <= '0;
      cfg_mul     <= '0;
      cfg_inc     <= '0;
      cfg_hi      <= '0;
      cfg_exp     <= '0;
    end else begin
      match_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cfg_mod     <= modulus;
            cfg_mul     <= multiplier;
            cfg_inc     <= increment;
            cfg_hi      <= seed_hi;
            cfg_exp     <= expected;
            base        <= {1'b0, seed_lo};
            found       <= 1'b0;
            match_count <= '0;
            if (bad_cfg) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_SCAN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (hit_any) begin
            match_valid <= 1'b1;
            match_seed  <= hit_seed;
            match_count <= match_count + WIDTH'(hit_cnt);
            if (!found) begin
              found      <= 1'b1;
              valid_seed <= hit_seed;
            end
          end
          if (last_blk || stop_on_hit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            base <= base + (WIDTH+1)'(LANES);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
